// File: rtl/wb_skid_stage_pkg.sv
// Shared types and constants for the MEM/WB skid stage: writeback select codes,
// load funct3 encodings and the buffered writeback entry.
package wb_skid_stage_pkg;

    localparam int WB_WIDTH  = 32;
    localparam int WB_REG_AW = 5;

    localparam logic [2:0] WB_SEL_ALU = 3'b000;
    localparam logic [2:0] WB_SEL_MEM = 3'b001;
    localparam logic [2:0] WB_SEL_PC4 = 3'b010;
    localparam logic [2:0] WB_SEL_IMM = 3'b100;
    localparam logic [2:0] WB_SEL_CSR = 3'b110;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef struct packed {
        logic [WB_WIDTH-1:0]  alu;
        logic [WB_WIDTH-1:0]  mem;
        logic [WB_WIDTH-1:0]  pc4;
        logic [WB_WIDTH-1:0]  imm;
        logic [WB_WIDTH-1:0]  csr;
        logic [2:0]           sel;
        logic [WB_REG_AW-1:0] rd;
        logic                 we;
    } wb_entry_t;

    // Upper source groups ignore bit0 so the mux only ever sees one code per source.
    function automatic logic [2:0] canon_sel(input logic [2:0] sel);
        logic [2:0] res;
        if (sel[2:1] != 2'b00) begin
            res = {sel[2:1], 1'b0};
        end else begin
            res = sel;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_skid_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the raw read word
// and sign- or zero-extends it according to the load type.
module wb_skid_stage_load_align
    import wb_skid_stage_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Misaligned halves fall back to offset 0; the trap is raised upstream.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (addr_lo == 2'd2) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            LD_LB:   data = {{(WIDTH-8){byte_s[7]}}, byte_s};
            LD_LH:   data = {{(WIDTH-16){half_s[15]}}, half_s};
            LD_LW:   data = rdata;
            LD_LBU:  data = {{(WIDTH-8){1'b0}}, byte_s};
            LD_LHU:  data = {{(WIDTH-16){1'b0}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_skid_stage.sv
// MEM/WB boundary: two-entry skid buffer carrying the five writeback candidates,
// with in_ready taken only from registered state.
module wb_skid_stage
    import wb_skid_stage_pkg::*;
#(
    parameter int WIDTH  = WB_WIDTH,
    parameter int REG_AW = WB_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_alu,
    input  logic [WIDTH-1:0]  in_rdata,
    input  logic [1:0]        in_addr_lo,
    input  logic [2:0]        in_ld_funct3,
    input  logic [WIDTH-1:0]  in_pc4,
    input  logic [WIDTH-1:0]  in_imm,
    input  logic [WIDTH-1:0]  in_csr,
    input  logic [2:0]        in_wb_sel,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_i0,
    output logic [WIDTH-1:0]  out_i1,
    output logic [WIDTH-1:0]  out_i2,
    output logic [WIDTH-1:0]  out_i3,
    output logic [WIDTH-1:0]  out_i4,
    output logic [2:0]        out_sel,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we
);

    wb_entry_t        in_entry_s;
    wb_entry_t        main_q, main_d;
    wb_entry_t        skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] ld_data_s;
    logic             accept_s;
    logic             release_s;

    wb_skid_stage_load_align #(
        .WIDTH (WIDTH)
    ) u_load_align (
        .rdata   (in_rdata),
        .addr_lo (in_addr_lo),
        .funct3  (in_ld_funct3),
        .data    (ld_data_s)
    );

    always_comb begin
        in_entry_s.alu = in_alu;
        in_entry_s.mem = ld_data_s;
        in_entry_s.pc4 = in_pc4;
        in_entry_s.imm = in_imm;
        in_entry_s.csr = in_csr;
        in_entry_s.sel = canon_sel(in_wb_sel);
        in_entry_s.rd  = in_rd;
        in_entry_s.we  = in_we;
    end

    assign in_ready  = ~skid_valid_q;
    assign accept_s  = in_valid & ~skid_valid_q & ~flush;
    assign release_s = main_valid_q & out_ready;

    // Skid never accepts while full, so a release with skid_valid cannot coincide with an accept.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (release_s) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_d       = in_entry_s;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            if (main_valid_q) begin
                skid_d       = in_entry_s;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = in_entry_s;
                main_valid_d = 1'b1;
            end
        end else begin
            main_valid_d = main_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_i0    = main_q.alu;
    assign out_i1    = main_q.mem;
    assign out_i2    = main_q.pc4;
    assign out_i3    = main_q.imm;
    assign out_i4    = main_q.csr;
    assign out_sel   = main_q.sel;
    assign out_rd    = main_q.rd;
    assign out_we    = main_q.we & main_valid_q;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Self-checking bench for wb_skid_stage: directed scenarios with inline checks
// plus a FIFO scoreboard of expected entries built from the driven inputs.
module tb_wb_skid_stage;
    import wb_skid_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, in_we, out_we;
    logic [31:0] in_alu, in_rdata, in_pc4, in_imm, in_csr;
    logic [31:0] out_i0, out_i1, out_i2, out_i3, out_i4;
    logic [1:0]  in_addr_lo;
    logic [2:0]  in_ld_funct3, in_wb_sel, out_sel;
    logic [4:0]  in_rd, out_rd;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    wb_entry_t sb[$];

    always #5 clk = ~clk;

    wb_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_rdata(in_rdata), .in_addr_lo(in_addr_lo),
        .in_ld_funct3(in_ld_funct3), .in_pc4(in_pc4), .in_imm(in_imm),
        .in_csr(in_csr), .in_wb_sel(in_wb_sel), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_i0(out_i0), .out_i1(out_i1), .out_i2(out_i2), .out_i3(out_i3),
        .out_i4(out_i4), .out_sel(out_sel), .out_rd(out_rd), .out_we(out_we)
    );

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f);
        logic [31:0] b, h, r;
        b = (w >> (8 * int'(a))) & 32'h0000_00FF;
        h = (a == 2'd2) ? ((w >> 16) & 32'h0000_FFFF) : (w & 32'h0000_FFFF);
        case (f)
            3'b000:  r = b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b001:  r = h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  r = b;
            3'b101:  r = h;
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic wb_entry_t exp_entry();
        wb_entry_t e;
        e.alu = in_alu;
        e.mem = ref_load(in_rdata, in_addr_lo, in_ld_funct3);
        e.pc4 = in_pc4;
        e.imm = in_imm;
        e.csr = in_csr;
        e.sel = (in_wb_sel[2:1] == 2'b00) ? in_wb_sel : {in_wb_sel[2:1], 1'b0};
        e.rd  = in_rd;
        e.we  = in_we;
        return e;
    endfunction

    // One clock: scoreboard pop on release, push on accept, then advance past the edge.
    task automatic step();
        wb_entry_t e, g;
        @(negedge clk);
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_pop++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got out_valid=1 alu=%h, required no pending entry", out_i0);
                end else begin
                    e = sb.pop_front();
                    g.alu = out_i0; g.mem = out_i1; g.pc4 = out_i2; g.imm = out_i3;
                    g.csr = out_i4; g.sel = out_sel; g.rd = out_rd; g.we = out_we;
                    if (g !== e) begin
                        errors++;
                        $display("FAIL sb_entry: got %h required %h", g, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_entry());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [31:0] tag);
        in_alu     = tag;
        in_rdata   = $urandom;
        in_addr_lo = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
            0:       in_ld_funct3 = 3'b000;
            1:       in_ld_funct3 = 3'b001;
            2:       in_ld_funct3 = 3'b010;
            3:       in_ld_funct3 = 3'b100;
            default: in_ld_funct3 = 3'b101;
        endcase
        in_pc4    = $urandom;
        in_imm    = $urandom;
        in_csr    = $urandom;
        in_wb_sel = 3'($urandom_range(0, 7));
        in_rd     = 5'($urandom_range(0, 31));
        in_we     = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got pending=%0d out_valid=%b required pending=0 out_valid=0", sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        set_entry(32'h0000_0001);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: got out_valid=%b out_we=%b required 0 0", out_valid, out_we);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] want);
        set_entry(32'h0000_0010);
        in_rdata = 32'h80FF_7F01; in_addr_lo = 2'd3; in_ld_funct3 = f3;
        in_wb_sel = 3'b001; in_rd = 5'd5; in_we = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_i1 !== want || out_sel !== 3'b001 || out_rd !== 5'd5 || out_we !== 1'b1) begin
            errors++;
            $display("FAIL load_f3_%b: got v=%b i1=%h sel=%b rd=%0d we=%b required 1 %h 001 5 1",
                     f3, out_valid, out_i1, out_sel, out_rd, out_we, want);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_release: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_canon();
        set_entry(32'h0000_0020);
        in_wb_sel = 3'b011; in_pc4 = 32'h0000_1004;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_sel !== 3'b010 || out_i2 !== 32'h0000_1004) begin
            errors++;
            $display("FAIL canon: got sel=%b i2=%h required 010 00001004", out_sel, out_i2);
        end
        drain();
    endtask

    task automatic test_back_pressure();
        int p0;
        out_ready = 1'b0; in_valid = 1'b1;
        set_entry(32'h0000_00A0); step();
        set_entry(32'h0000_00B0); step();
        set_entry(32'h0000_00C0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_i0 !== 32'h0000_00A0) begin
            errors++;
            $display("FAIL bp_full: got in_ready=%b out_valid=%b i0=%h required 0 1 000000a0", in_ready, out_valid, out_i0);
        end
        step();
        p0 = n_pop;
        drain();
        checks++;
        if (n_pop - p0 != 2) begin
            errors++;
            $display("FAIL bp_count: got %0d released required 2", n_pop - p0);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        out_ready = 1'b0; in_valid = 1'b1;
        set_entry(32'h0000_0100); step();
        out_ready = 1'b1;
        p0 = n_pop;
        for (int i = 1; i <= 10; i++) begin
            set_entry(32'h0000_0100 + 32'(i));
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: got in_ready=%b out_valid=%b required 1 1", i, in_ready, out_valid);
            end
            step();
        end
        checks++;
        if (n_pop - p0 != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d released required 10", n_pop - p0);
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        set_entry(32'h0000_00F1); step();
        set_entry(32'h0000_00F2); step();
        set_entry(32'h0000_00F3); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b1;
        set_entry(32'h0000_00F4); step();
        set_entry(32'h0000_00F5); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_block: got out_valid=%b i0=%h required 0", out_valid, out_i0);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            set_entry(32'h0001_0000 + 32'(i));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_load(3'b000, 32'hFFFF_FF80);
        test_load(3'b100, 32'h0000_0080);
        test_canon();
        test_back_pressure();
        test_back_to_back();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
